// File: rtl/mcu_ctrl_pkg.sv
// Shared encodings for the MCU control unit: instruction classes, FSM states,
// ALU modes and status-register bit positions.
package mcu_ctrl_pkg;

  // Instruction classes (IR[15:12])
  localparam logic [3:0] CL_NOP   = 4'b0000;
  localparam logic [3:0] CL_ALU_M = 4'b0001;  // ACC <- ALU(ACC, M[addr])
  localparam logic [3:0] CL_ALU_W = 4'b0010;  // M[addr] <- ALU(ACC, M[addr])
  localparam logic [3:0] CL_ALU_I = 4'b0011;  // ACC <- ALU(ACC, imm)
  localparam logic [3:0] CL_JMP   = 4'b0100;
  localparam logic [3:0] CL_JCC   = 4'b0101;
  localparam logic [3:0] CL_HALT  = 4'b0110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_e;

  // ALU modes that matter to the sequencer
  localparam logic [3:0] MODE_ADD  = 4'b0000;
  localparam logic [3:0] MODE_SUB  = 4'b0001;
  localparam logic [3:0] MODE_IDLE = 4'b0011;  // parked value when ALU unused
  localparam logic [3:0] MODE_C7   = 4'b0111;
  localparam logic [3:0] MODE_CF   = 4'b1111;

  // SR = {Z,C,S,O}
  localparam int SR_Z = 3;
  localparam int SR_C = 2;
  localparam int SR_S = 1;
  localparam int SR_O = 0;

  // Only these modes produce a meaningful carry out of the ALU
  function automatic logic mode_has_carry(input logic [3:0] m);
    return (m == MODE_ADD) || (m == MODE_SUB) || (m == MODE_C7) || (m == MODE_CF);
  endfunction

endpackage

// File: rtl/mcu_decode.sv
// Combinational instruction decoder: classifies IR and resolves branch conditions.
module mcu_decode
  import mcu_ctrl_pkg::*;
(
  input  logic [15:0] ir_i,
  input  logic [3:0]  sr_i,
  output logic        uses_mem_o,
  output logic        writes_mem_o,
  output logic        writes_acc_o,
  output logic        is_jump_o,
  output logic        jump_taken_o,
  output logic        is_halt_o,
  output logic        is_illegal_o,
  output logic        updates_carry_o
);

  logic [3:0] cls;
  logic [3:0] cond;
  logic       cond_bit;

  assign cls  = ir_i[15:12];
  assign cond = ir_i[11:8];

  // cond[1:0]: 00 Z, 01 C, 10 S, 11 O -> SR index 3 - cond[1:0]
  assign cond_bit = sr_i[2'd3 - cond[1:0]];

  // Class decode and branch resolution
  always_comb begin
    uses_mem_o      = (cls == CL_ALU_M) || (cls == CL_ALU_W);
    writes_mem_o    = (cls == CL_ALU_W);
    writes_acc_o    = (cls == CL_ALU_M) || (cls == CL_ALU_I);
    is_jump_o       = (cls == CL_JMP) || (cls == CL_JCC);
    jump_taken_o    = (cls == CL_JMP) || ((cls == CL_JCC) && (cond_bit ^ cond[3]));
    is_halt_o       = (cls == CL_HALT);
    is_illegal_o    = (cls > CL_HALT);
    updates_carry_o = (writes_acc_o || writes_mem_o) && mode_has_carry(cond);
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer for the 8-bit MCU. Owns PC, ACC, SR
// and IR; drives program/data memory and the external combinational ALU.
module alu_sequencer
  import mcu_ctrl_pkg::*;
#(
  parameter int          DW       = 8,
  parameter int          AW       = 8,
  parameter int          IW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] imem_addr,
  output logic          imem_rd,
  input  logic [IW-1:0] imem_data,
  output logic [AW-1:0] dmem_addr,
  output logic          dmem_rd,
  output logic          dmem_wr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  output logic [3:0]    alu_mode,
  output logic          alu_en,
  output logic [DW-1:0] alu_op1,
  output logic [DW-1:0] alu_op2,
  output logic [3:0]    alu_cflags,
  input  logic [DW-1:0] alu_out,
  input  logic [3:0]    alu_flags,
  output logic [DW-1:0] acc,
  output logic [3:0]    sr,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          illegal
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [3:0]    sr_q, sr_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [IW-1:0] ir_cur;

  logic uses_mem, writes_mem, writes_acc, is_jump, jump_taken;
  logic is_halt, is_illegal, updates_carry;

  // In DECODE the instruction is still on imem_data; IR only holds it from EXEC on
  assign ir_cur = (state_q == ST_DECODE) ? imem_data : ir_q;

  mcu_decode u_dec (
    .ir_i            (ir_cur[15:0]),
    .sr_i            (sr_q),
    .uses_mem_o      (uses_mem),
    .writes_mem_o    (writes_mem),
    .writes_acc_o    (writes_acc),
    .is_jump_o       (is_jump),
    .jump_taken_o    (jump_taken),
    .is_halt_o       (is_halt),
    .is_illegal_o    (is_illegal),
    .updates_carry_o (updates_carry)
  );

  assign imem_addr  = pc_q;
  assign dmem_addr  = AW'(ir_cur[7:0]);
  assign alu_op1    = acc_q;
  assign alu_cflags = sr_q;
  assign acc        = acc_q;
  assign sr         = sr_q;
  assign pc         = pc_q;
  assign busy       = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_EXEC);
  assign halted     = (state_q == ST_HALT);

  // Architectural state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      acc_q   <= '0;
      sr_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      sr_q    <= sr_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state and per-state strobes
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    acc_d      = acc_q;
    sr_d       = sr_q;
    ir_d       = ir_q;
    imem_rd    = 1'b0;
    dmem_rd    = 1'b0;
    dmem_wr    = 1'b0;
    dmem_wdata = '0;
    alu_en     = 1'b0;
    alu_mode   = MODE_IDLE;
    alu_op2    = '0;
    illegal    = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = RESET_PC;
        end
      end
      ST_FETCH: begin
        imem_rd = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ir_d    = imem_data;
        dmem_rd = uses_mem;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (writes_acc || writes_mem) begin
          alu_en   = 1'b1;
          alu_mode = ir_q[11:8];
          alu_op2  = uses_mem ? dmem_rdata : DW'(ir_q[7:0]);
          sr_d[SR_Z] = alu_flags[SR_Z];
          sr_d[SR_S] = alu_flags[SR_S];
          sr_d[SR_O] = alu_flags[SR_O];
          if (updates_carry) sr_d[SR_C] = alu_flags[SR_C];
        end
        if (writes_acc) acc_d = alu_out;
        if (writes_mem) begin
          dmem_wr    = 1'b1;
          dmem_wdata = alu_out;
        end
        illegal = is_illegal;
        pc_d    = (is_jump && jump_taken) ? AW'(ir_q[7:0]) : pc_q + AW'(1);
        state_d = is_halt ? ST_HALT : ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: program/data memories and a simple ALU
// are modelled here; expected values are hand-computed constants.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data = '0;
  logic [7:0]  dmem_addr;
  logic        dmem_rd, dmem_wr;
  logic [7:0]  dmem_wdata;
  logic [7:0]  dmem_rdata = '0;
  logic [3:0]  alu_mode;
  logic        alu_en;
  logic [7:0]  alu_op1, alu_op2;
  logic [3:0]  alu_cflags;
  logic [7:0]  alu_out;
  logic [3:0]  alu_flags;
  logic [7:0]  acc;
  logic [3:0]  sr;
  logic [7:0]  pc;
  logic        busy, halted, illegal;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .dmem_addr(dmem_addr), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .alu_mode(alu_mode), .alu_en(alu_en), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_cflags(alu_cflags), .alu_out(alu_out), .alu_flags(alu_flags),
    .acc(acc), .sr(sr), .pc(pc), .busy(busy), .halted(halted), .illegal(illegal)
  );

  // Memories: contents loaded by the stimulus; writes are logged, not stored
  logic [15:0] imem [256];
  logic [7:0]  dmem [256];
  int          wr_cnt = 0;
  logic [7:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;

  always @(posedge clk) begin
    if (imem_rd) imem_data <= imem[imem_addr];
    if (dmem_rd) dmem_rdata <= dmem[dmem_addr];
    if (dmem_wr) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= dmem_addr;
      wr_data <= dmem_wdata;
    end
  end

  // External ALU: add/sub drive carry and overflow, logic ops drive C=O=0
  always_comb begin
    logic [8:0] s;
    logic       c, o;
    s = '0; c = 1'b0; o = 1'b0;
    case (alu_mode)
      4'b0000: begin
        s = {1'b0, alu_op1} + {1'b0, alu_op2};
        alu_out = s[7:0]; c = s[8];
        o = (alu_op1[7] == alu_op2[7]) && (alu_out[7] != alu_op1[7]);
      end
      4'b0001: begin
        s = {1'b0, alu_op1} - {1'b0, alu_op2};
        alu_out = s[7:0]; c = s[8];
        o = (alu_op1[7] != alu_op2[7]) && (alu_out[7] != alu_op1[7]);
      end
      4'b0011: alu_out = alu_op2;
      4'b0100: alu_out = alu_op1 & alu_op2;
      4'b0101: alu_out = alu_op1 | alu_op2;
      4'b0110: alu_out = alu_op1 ^ alu_op2;
      default: alu_out = alu_op1;
    endcase
    alu_flags = {(alu_out == 8'h00), c, alu_out[7], o};
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'h0000;
      dmem[i] = 8'h00;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int wc;

  initial begin
    // ---- 1: reset state, immediate loads/adds, latency, HALT, restart ----
    clear_mem();
    imem[0] = 16'h3305;  // ACC <- 05
    imem[1] = 16'h3003;  // ACC <- ACC + 03
    imem[2] = 16'h6000;  // HALT
    do_reset();
    chk("rst_acc", acc, 8'h00);
    chk("rst_sr", sr, 4'h0);
    chk("rst_pc", pc, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_strobes", {imem_rd, dmem_rd, dmem_wr, alu_en, illegal}, 5'b0);
    chk("rst_mode", alu_mode, 4'b0011);

    pulse_start();
    chk("fetch_rd", imem_rd, 1'b1);
    chk("fetch_addr", imem_addr, 8'h00);
    chk("fetch_busy", busy, 1'b1);
    chk("fetch_alu_en", alu_en, 1'b0);
    ticks(2);
    chk("exec_alu_en", alu_en, 1'b1);
    chk("exec_mode", alu_mode, 4'b0011);
    chk("exec_op2", alu_op2, 8'h05);
    tick();
    chk("i1_acc", acc, 8'h05);
    chk("i1_sr", sr, 4'b0000);
    chk("i1_pc", pc, 8'h01);
    ticks(3);
    chk("i2_acc", acc, 8'h08);
    chk("i2_sr", sr, 4'b0000);
    ticks(3);
    chk("halt_halted", halted, 1'b1);
    chk("halt_busy", busy, 1'b0);
    ticks(10);
    chk("halt_hold", {pc, acc, sr, halted}, {8'h03, 8'h08, 4'h0, 1'b1});
    pulse_start();
    chk("restart_addr", imem_addr, 8'h00);
    chk("restart_acc", acc, 8'h08);
    tick();               // DECODE
    start = 1'b1;         // must be ignored while busy
    tick();
    start = 1'b0;
    chk("busy_start_ignored", alu_en, 1'b1);
    tick();
    chk("busy_start_pc", pc, 8'h01);
    chk("busy_start_acc", acc, 8'h05);

    // ---- 2: memory write, carry retention, branching, PC wrap ----
    clear_mem();
    imem[8'h00] = 16'h33FF;  // ACC <- FF
    imem[8'h01] = 16'h2002;  // M[2] <- ACC + M[2]
    imem[8'h02] = 16'h3400;  // ACC <- ACC & 00
    imem[8'h03] = 16'h5040;  // jump if Z -> 40
    imem[8'h40] = 16'h5840;  // jump if !Z (not taken)
    imem[8'h41] = 16'h40FF;  // JMP FF
    imem[8'hFF] = 16'h5840;  // not taken, PC wraps
    dmem[2] = 8'h01;
    do_reset();
    wc = wr_cnt;
    pulse_start();
    ticks(3);
    chk("ldff_acc", acc, 8'hFF);
    chk("ldff_sr", sr, 4'b0010);
    tick();
    chk("dec_dmem_rd", dmem_rd, 1'b1);
    chk("dec_dmem_addr", dmem_addr, 8'h02);
    tick();
    chk("exec_wr", {dmem_wr, dmem_rd}, 2'b10);
    chk("exec_wdata", dmem_wdata, 8'h00);
    chk("exec_waddr", dmem_addr, 8'h02);
    tick();
    chk("memw_sr", sr, 4'b1100);
    chk("memw_acc", acc, 8'hFF);
    chk("memw_log", {wr_cnt - wc, wr_addr, wr_data}, {32'd1, 8'h02, 8'h00});
    ticks(3);
    chk("and_sr_carry_kept", sr, 4'b1100);
    chk("and_acc", acc, 8'h00);
    ticks(3);
    chk("jz_taken", imem_addr, 8'h40);
    ticks(3);
    chk("jnz_not_taken", imem_addr, 8'h41);
    ticks(3);
    chk("jmp_ff", imem_addr, 8'hFF);
    ticks(3);
    chk("pc_wrap", pc, 8'h00);

    // ---- 3: reset during EXEC of a memory write ----
    clear_mem();
    imem[0] = 16'h3377;  // ACC <- 77
    imem[1] = 16'h2001;  // M[1] <- ACC + M[1]
    dmem[1] = 8'h05;
    do_reset();
    pulse_start();
    ticks(3);
    chk("pre_acc", acc, 8'h77);
    ticks(2);
    chk("pre_wr", dmem_wr, 1'b1);
    wc = wr_cnt;
    rst_n = 1'b0;
    #1;
    chk("arst_wr", dmem_wr, 1'b0);
    chk("arst_state", {acc, sr, pc, busy}, {8'h00, 4'h0, 8'h00, 1'b0});
    tick();
    chk("arst_no_write", wr_cnt - wc, 32'd0);
    rst_n = 1'b1;

    // ---- 4: illegal class ----
    clear_mem();
    imem[0] = 16'h3380;  // ACC <- 80 (S set)
    imem[1] = 16'hA000;  // illegal
    imem[2] = 16'h6000;
    do_reset();
    pulse_start();
    ticks(3);
    chk("ill_pre", {acc, sr}, {8'h80, 4'b0010});
    tick();
    chk("ill_decode", illegal, 1'b0);
    tick();
    chk("ill_exec", illegal, 1'b1);
    chk("ill_alu_idle", {alu_en, alu_mode}, {1'b0, 4'b0011});
    tick();
    chk("ill_after", illegal, 1'b0);
    chk("ill_state", {acc, sr, pc}, {8'h80, 4'b0010, 8'h02});

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
